// File: rtl/rvfi_shadow_regcheck.sv
// Shadow register file and PC checker for up to NRET RVFI retirement channels.
// The first violation is latched into sticky error registers. Checking continues after an error.
module rvfi_shadow_regcheck #(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter bit ZERO_INIT = 1'b1,
  parameter bit CHECK_PC  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [5*NRET-1:0]    rvfi_rs1_addr,
  input  logic [5*NRET-1:0]    rvfi_rs2_addr,
  input  logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
  input  logic [5*NRET-1:0]    rvfi_rd_addr,
  input  logic [XLEN*NRET-1:0] rvfi_rd_wdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  output logic                 err,
  output logic [2:0]           err_kind,
  output logic [1:0]           err_chan,
  output logic [63:0]          err_order,
  output logic [31:0]          retired_cnt
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  logic [31:0]     known_q, known_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_known_q, pc_known_d;
  logic [63:0]     exp_order_q, exp_order_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q;
  logic [2:0]      err_kind_q;
  logic [1:0]      err_chan_q;
  logic [63:0]     err_order_q;

  logic            hit;
  logic [2:0]      hit_kind;
  logic [1:0]      hit_chan;
  logic [63:0]     hit_order;
  logic [2:0]      kind;
  logic [63:0]     ord;
  logic [4:0]      rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0] rs1_v, rs2_v, rd_v, pc_r, pc_w;
  logic            rs1_bad, rs2_bad;

  // Walk the channels in order; each channel sees the shadow state already updated by earlier valid channels.
  always_comb begin
    regs_d      = regs_q;
    known_d     = known_q;
    pc_d        = pc_q;
    pc_known_d  = pc_known_q;
    exp_order_d = exp_order_q;
    cnt_d       = cnt_q;
    hit         = 1'b0;
    hit_kind    = 3'd0;
    hit_chan    = 2'd0;
    hit_order   = 64'd0;
    kind        = 3'd0;
    ord         = 64'd0;
    rs1_a       = 5'd0;
    rs2_a       = 5'd0;
    rd_a        = 5'd0;
    rs1_v       = '0;
    rs2_v       = '0;
    rd_v        = '0;
    pc_r        = '0;
    pc_w        = '0;
    rs1_bad     = 1'b0;
    rs2_bad     = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid[k]) begin
        ord   = rvfi_order[64*k +: 64];
        rs1_a = rvfi_rs1_addr[5*k +: 5];
        rs2_a = rvfi_rs2_addr[5*k +: 5];
        rd_a  = rvfi_rd_addr[5*k +: 5];
        rs1_v = rvfi_rs1_rdata[XLEN*k +: XLEN];
        rs2_v = rvfi_rs2_rdata[XLEN*k +: XLEN];
        rd_v  = rvfi_rd_wdata[XLEN*k +: XLEN];
        pc_r  = rvfi_pc_rdata[XLEN*k +: XLEN];
        pc_w  = rvfi_pc_wdata[XLEN*k +: XLEN];
        rs1_bad = (rs1_a == 5'd0) ? (rs1_v != '0) : (known_d[rs1_a] && (rs1_v != regs_d[rs1_a]));
        rs2_bad = (rs2_a == 5'd0) ? (rs2_v != '0) : (known_d[rs2_a] && (rs2_v != regs_d[rs2_a]));
        if (ord != exp_order_d)                        kind = 3'd1;
        else if (CHECK_PC && pc_known_d && pc_r != pc_d) kind = 3'd2;
        else if (rs1_bad)                              kind = 3'd3;
        else if (rs2_bad)                              kind = 3'd4;
        else if (rd_a == 5'd0 && rd_v != '0)           kind = 3'd5;
        else                                           kind = 3'd0;
        if (kind != 3'd0 && !hit) begin
          hit       = 1'b1;
          hit_kind  = kind;
          hit_chan  = 2'(k);
          hit_order = ord;
        end
        if (rd_a != 5'd0) begin
          regs_d[rd_a]  = rd_v;
          known_d[rd_a] = 1'b1;
        end
        pc_d        = pc_w;
        pc_known_d  = 1'b1;
        exp_order_d = exp_order_d + 64'd1;
        if (cnt_d != '1) cnt_d = cnt_d + 32'd1;
      end
    end
  end

  // Only the first violation after reset is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q      <= '{default: '0};
      known_q     <= ZERO_INIT ? '1 : '0;
      pc_q        <= '0;
      pc_known_q  <= 1'b0;
      exp_order_q <= 64'd0;
      cnt_q       <= 32'd0;
      err_q       <= 1'b0;
      err_kind_q  <= 3'd0;
      err_chan_q  <= 2'd0;
      err_order_q <= 64'd0;
    end else begin
      regs_q      <= regs_d;
      known_q     <= known_d;
      pc_q        <= pc_d;
      pc_known_q  <= pc_known_d;
      exp_order_q <= exp_order_d;
      cnt_q       <= cnt_d;
      if (!err_q && hit) begin
        err_q       <= 1'b1;
        err_kind_q  <= hit_kind;
        err_chan_q  <= hit_chan;
        err_order_q <= hit_order;
      end
    end
  end

  assign err         = err_q;
  assign err_kind    = err_kind_q;
  assign err_chan    = err_chan_q;
  assign err_order   = err_order_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_rvfi_shadow_regcheck.sv
// Directed bench: a two-channel zero-init checker driven from a vector table, plus a
// single-channel unknown-init checker with PC checking off, exercised by a hand-written sequence.
module tb_rvfi_shadow_regcheck;

  typedef struct packed {
    logic        v;
    logic [63:0] ord;
    logic [4:0]  rs1;
    logic [31:0] rs1d;
    logic [4:0]  rs2;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [31:0] rdd;
    logic [31:0] pcr;
    logic [31:0] pcw;
  } chan_t;

  typedef struct packed {
    logic        rst;
    chan_t       c0;
    chan_t       c1;
    logic        eErr;
    logic [2:0]  eKind;
    logic [1:0]  eChan;
    logic [63:0] eOrd;
    logic [31:0] eCnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   aValid = '0;
  logic [127:0] aOrder = '0;
  logic [9:0]   aRs1Addr = '0, aRs2Addr = '0, aRdAddr = '0;
  logic [63:0]  aRs1Data = '0, aRs2Data = '0, aRdData = '0, aPcR = '0, aPcW = '0;
  logic         aErr;
  logic [2:0]   aKind;
  logic [1:0]   aChan;
  logic [63:0]  aOrd;
  logic [31:0]  aCnt;

  logic         bValid = 1'b0;
  logic [63:0]  bOrder = '0;
  logic [4:0]   bRs1Addr = '0, bRs2Addr = '0, bRdAddr = '0;
  logic [31:0]  bRs1Data = '0, bRs2Data = '0, bRdData = '0, bPcR = '0, bPcW = '0;
  logic         bErr;
  logic [2:0]   bKind;
  logic [1:0]   bChan;
  logic [63:0]  bOrd;
  logic [31:0]  bCnt;

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  rvfi_shadow_regcheck #(.XLEN(32), .NRET(2), .ZERO_INIT(1'b1), .CHECK_PC(1'b1)) dutA (
    .clk(clk), .reset(reset), .rvfi_valid(aValid), .rvfi_order(aOrder),
    .rvfi_rs1_addr(aRs1Addr), .rvfi_rs2_addr(aRs2Addr),
    .rvfi_rs1_rdata(aRs1Data), .rvfi_rs2_rdata(aRs2Data),
    .rvfi_rd_addr(aRdAddr), .rvfi_rd_wdata(aRdData),
    .rvfi_pc_rdata(aPcR), .rvfi_pc_wdata(aPcW),
    .err(aErr), .err_kind(aKind), .err_chan(aChan), .err_order(aOrd), .retired_cnt(aCnt)
  );

  rvfi_shadow_regcheck #(.XLEN(32), .NRET(1), .ZERO_INIT(1'b0), .CHECK_PC(1'b0)) dutB (
    .clk(clk), .reset(reset), .rvfi_valid(bValid), .rvfi_order(bOrder),
    .rvfi_rs1_addr(bRs1Addr), .rvfi_rs2_addr(bRs2Addr),
    .rvfi_rs1_rdata(bRs1Data), .rvfi_rs2_rdata(bRs2Data),
    .rvfi_rd_addr(bRdAddr), .rvfi_rd_wdata(bRdData),
    .rvfi_pc_rdata(bPcR), .rvfi_pc_wdata(bPcW),
    .err(bErr), .err_kind(bKind), .err_chan(bChan), .err_order(bOrd), .retired_cnt(bCnt)
  );

  function automatic chan_t ch(input logic [63:0] ord, input logic [4:0] rs1, input logic [31:0] rs1d,
                               input logic [4:0] rs2, input logic [31:0] rs2d, input logic [4:0] rd,
                               input logic [31:0] rdd, input logic [31:0] pcr, input logic [31:0] pcw);
    ch = '{v: 1'b1, ord: ord, rs1: rs1, rs1d: rs1d, rs2: rs2, rs2d: rs2d, rd: rd, rdd: rdd, pcr: pcr, pcw: pcw};
  endfunction

  function automatic chan_t pcOnly(input logic [63:0] ord, input logic [31:0] pcr);
    pcOnly = ch(ord, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, pcr, pcr + 32'd4);
  endfunction

  task automatic addVec(input logic rst, input chan_t c0, input chan_t c1, input logic e,
                        input logic [2:0] k, input logic [1:0] c, input logic [63:0] o, input logic [31:0] n);
    vecs.push_back('{rst: rst, c0: c0, c1: c1, eErr: e, eKind: k, eChan: c, eOrd: o, eCnt: n});
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    aValid   = {v.c1.v, v.c0.v};
    aOrder   = {v.c1.ord, v.c0.ord};
    aRs1Addr = {v.c1.rs1, v.c0.rs1};
    aRs1Data = {v.c1.rs1d, v.c0.rs1d};
    aRs2Addr = {v.c1.rs2, v.c0.rs2};
    aRs2Data = {v.c1.rs2d, v.c0.rs2d};
    aRdAddr  = {v.c1.rd, v.c0.rd};
    aRdData  = {v.c1.rdd, v.c0.rdd};
    aPcR     = {v.c1.pcr, v.c0.pcr};
    aPcW     = {v.c1.pcw, v.c0.pcw};
    @(posedge clk);
    #1;
  endtask

  task automatic applyB(input logic [63:0] ord, input logic [4:0] rs1, input logic [31:0] rs1d,
                        input logic [4:0] rs2, input logic [31:0] rs2d, input logic [4:0] rd,
                        input logic [31:0] rdd, input logic [31:0] pcr);
    bValid = 1'b1; bOrder = ord; bRs1Addr = rs1; bRs1Data = rs1d; bRs2Addr = rs2; bRs2Data = rs2d;
    bRdAddr = rd; bRdData = rdd; bPcR = pcr; bPcW = pcr + 32'd4;
    @(posedge clk);
    #1;
    bValid = 1'b0;
  endtask

  task automatic checkB(input string tag, input logic e, input logic [2:0] k, input logic [63:0] o, input logic [31:0] n);
    checkOutput({tag, "_err"}, 64'(bErr), 64'(e));
    checkOutput({tag, "_kind"}, 64'(bKind), 64'(k));
    checkOutput({tag, "_chan"}, 64'(bChan), 64'd0);
    checkOutput({tag, "_order"}, bOrd, o);
    checkOutput({tag, "_cnt"}, 64'(bCnt), 64'(n));
  endtask

  initial begin
    chan_t idle;
    idle = '0;
    // Single-lane pc chain 0,4,8,C with x5 written then read.
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, ch(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4), idle, 0, 0, 0, 0, 1);
    addVec(0, ch(1, 0, 0, 0, 0, 5, 32'h55, 32'h4, 32'h8), idle, 0, 0, 0, 0, 2);
    addVec(0, ch(2, 5, 32'h55, 0, 0, 0, 0, 32'h8, 32'hC), idle, 0, 0, 0, 0, 3);
    addVec(0, ch(3, 0, 0, 5, 32'h55, 5, 32'h66, 32'hC, 32'h10), idle, 0, 0, 0, 0, 4);
    addVec(0, ch(4, 5, 32'h66, 0, 0, 0, 0, 32'h10, 32'h14), idle, 0, 0, 0, 0, 5);
    // Same-cycle forwarding of x3 from ch0 to ch1, good then bad data.
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, ch(0, 0, 0, 0, 0, 3, 32'h1234, 32'h0, 32'h4), ch(1, 3, 32'h1234, 0, 0, 0, 0, 32'h4, 32'h8), 0, 0, 0, 0, 2);
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, ch(0, 0, 0, 0, 0, 3, 32'h1234, 32'h0, 32'h4), ch(1, 3, 32'h1235, 0, 0, 0, 0, 32'h4, 32'h8), 1, 3, 1, 1, 2);
    addVec(0, idle, idle, 1, 3, 1, 1, 2);
    // Order gap wins over a simultaneous rs2 mismatch.
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, pcOnly(0, 32'h0), idle, 0, 0, 0, 0, 1);
    addVec(0, ch(2, 0, 0, 0, 32'h99, 0, 0, 32'h4, 32'h8), idle, 1, 1, 0, 2, 2);
    addVec(0, pcOnly(2, 32'h8), idle, 1, 1, 0, 2, 3);
    // Lowest failing channel is reported: ch0 rs1 vs ch1 pc against forwarded PC.
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, ch(0, 0, 32'h1, 0, 0, 0, 0, 32'h0, 32'h4), pcOnly(1, 32'h100), 1, 3, 0, 0, 2);
    // Same rd in both channels: ch1 wins; an invalid ch0 consumes no order number.
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, ch(0, 0, 0, 0, 0, 9, 32'h11, 32'h0, 32'h4), ch(1, 0, 0, 0, 0, 9, 32'h22, 32'h4, 32'h8), 0, 0, 0, 0, 2);
    addVec(0, ch(2, 9, 32'h22, 0, 0, 0, 0, 32'h8, 32'hC), idle, 0, 0, 0, 0, 3);
    addVec(0, '{v: 1'b0, ord: 64'd77, rs1: 5'd9, rs1d: 32'hBAD, rs2: 5'd0, rs2d: 32'h0, rd: 5'd9, rdd: 32'h1,
               pcr: 32'h0, pcw: 32'h0}, pcOnly(3, 32'hC), 0, 0, 0, 0, 4);
    // Write to x0 latches kind 5, which then sticks through later errors.
    addVec(1, idle, idle, 0, 0, 0, 0, 0);
    addVec(0, ch(0, 0, 0, 0, 0, 0, 32'h1, 32'h0, 32'h4), idle, 1, 5, 0, 0, 1);
    addVec(0, ch(1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h8), idle, 1, 5, 0, 0, 2);
    addVec(0, pcOnly(5, 32'h8), idle, 1, 5, 0, 0, 3);
    // Reset with a retirement in the same cycle; then restart at order 0 with no PC check.
    addVec(1, pcOnly(99, 32'h40), idle, 0, 0, 0, 0, 0);
    addVec(0, pcOnly(0, 32'h500), idle, 0, 0, 0, 0, 1);
    addVec(0, pcOnly(1, 32'h600), idle, 1, 2, 0, 1, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d_err", i), 64'(aErr), 64'(vecs[i].eErr));
      checkOutput($sformatf("row%0d_kind", i), 64'(aKind), 64'(vecs[i].eKind));
      checkOutput($sformatf("row%0d_chan", i), 64'(aChan), 64'(vecs[i].eChan));
      checkOutput($sformatf("row%0d_order", i), aOrd, vecs[i].eOrd);
      checkOutput($sformatf("row%0d_cnt", i), 64'(aCnt), 64'(vecs[i].eCnt));
    end
    aValid = '0;

    // Unknown-init lane: unread registers are not checked until written; PC is never checked.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkB("b_reset", 0, 0, 0, 0);
    applyB(0, 5'd7, 32'hDEAD, 5'd0, 32'h0, 5'd0, 32'h0, 32'h1000);
    checkB("b_unknown_read", 0, 0, 0, 1);
    applyB(1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h10, 32'h2000);
    checkB("b_write_x7", 0, 0, 0, 2);
    applyB(2, 5'd0, 32'h0, 5'd7, 32'h11, 5'd0, 32'h0, 32'h3000);
    checkB("b_rs2_mismatch", 1, 4, 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
